decode_writeback: RTL

- Decode/write-back stage of the sequential Y86-64 core, directly downstream of fetch.
- Consumes icode, ifun, rA and rB from fetch, and selects source and destination register IDs.
- Reads valA and valB from an internal 15-entry x 64-bit register file.
- At the end of the instruction cycle, commits valE (from execute) and valM (from memory) back into the register file.

---
 rtl/decode_writeback_pkg.sv | 25 ++
 rtl/decode_writeback_if.sv | 37 +++
 rtl/decode_writeback_regfile.sv | 52 +++++
 rtl/decode_writeback.sv | 93 +++++++++
 4 files changed

// File: rtl/decode_writeback_pkg.sv
// Shared Y86-64 definitions for the decode/write-back slice.
// Contents: data width, register count, special register IDs and the
// instruction codes used by source/destination selection.
package y86_pkg;

   localparam int unsigned XLEN  = 64;
   localparam int unsigned NREGS = 15;

   localparam logic [3:0] REG_RSP  = 4'h4;
   localparam logic [3:0] REG_NONE = 4'hF;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

endpackage

// File: rtl/decode_writeback_if.sv
// Bus between the core (fetch/execute/memory side) and the decode/write-back
// stage.
//   master: drives icode, ifun, rA, rB, cnd, valE, valM, wb_en, dbg_sel;
//           receives srcA, srcB, dstE, dstM, valA, valB, dbg_val.
//   slave : the decode/write-back stage (mirror of master).
interface decode_writeback_if;
   import y86_pkg::*;

   logic [3:0]      icode;
   logic [3:0]      ifun;
   logic [3:0]      rA;
   logic [3:0]      rB;
   logic            cnd;
   logic [XLEN-1:0] valE;
   logic [XLEN-1:0] valM;
   logic            wb_en;
   logic [3:0]      dbg_sel;

   logic [3:0]      srcA;
   logic [3:0]      srcB;
   logic [3:0]      dstE;
   logic [3:0]      dstM;
   logic [XLEN-1:0] valA;
   logic [XLEN-1:0] valB;
   logic [XLEN-1:0] dbg_val;

   modport master (
      output icode, ifun, rA, rB, cnd, valE, valM, wb_en, dbg_sel,
      input  srcA, srcB, dstE, dstM, valA, valB, dbg_val
   );

   modport slave (
      input  icode, ifun, rA, rB, cnd, valE, valM, wb_en, dbg_sel,
      output srcA, srcB, dstE, dstM, valA, valB, dbg_val
   );

endinterface

// File: rtl/decode_writeback_regfile.sv
// 15 x XLEN architectural register file.
// Ports:
//   clk, rst              : clock, synchronous active-high clear of all entries
//   rd_a_id/rd_a_val      : async read port A (ID F reads 0)
//   rd_b_id/rd_b_val      : async read port B (ID F reads 0)
//   rd_d_id/rd_d_val      : async debug read port (ID F reads 0)
//   wr_en                 : global write enable for both write ports
//   wr_e_id/wr_e_val      : write port E (ID F = no write)
//   wr_m_id/wr_m_val      : write port M (ID F = no write), wins over E
module regfile
   import y86_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [3:0]      rd_a_id,
   output logic [XLEN-1:0] rd_a_val,
   input  logic [3:0]      rd_b_id,
   output logic [XLEN-1:0] rd_b_val,
   input  logic [3:0]      rd_d_id,
   output logic [XLEN-1:0] rd_d_val,
   input  logic            wr_en,
   input  logic [3:0]      wr_e_id,
   input  logic [XLEN-1:0] wr_e_val,
   input  logic [3:0]      wr_m_id,
   input  logic [XLEN-1:0] wr_m_val
);

   logic [XLEN-1:0] regs [NREGS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en) begin
         if (wr_e_id != REG_NONE) begin
            regs[wr_e_id] <= wr_e_val;
         end
         // M port is assigned last so it overrides E when both target one ID.
         if (wr_m_id != REG_NONE) begin
            regs[wr_m_id] <= wr_m_val;
         end
      end
   end

   always_comb begin
      rd_a_val = (rd_a_id == REG_NONE) ? '0 : regs[rd_a_id];
      rd_b_val = (rd_b_id == REG_NONE) ? '0 : regs[rd_b_id];
      rd_d_val = (rd_d_id == REG_NONE) ? '0 : regs[rd_d_id];
   end

endmodule

// File: rtl/decode_writeback.sv
// Decode/write-back stage of the sequential Y86-64 core.
// Selects source/destination register IDs from icode/rA/rB (cmovXX write
// qualified by cnd), reads valA/valB from the register file and commits
// valE/valM at the end of the instruction cycle when wb_en is high.
// Ports:
//   clk, rst : core clock, synchronous active-high reset
//   bus      : decode_writeback_if.slave (fetch fields, execute/memory
//              results, commit enable, debug read, selected IDs and reads)
module decode_writeback
   import y86_pkg::*;
(
   input logic                clk,
   input logic                rst,
   decode_writeback_if.slave  bus
);

   logic [3:0] src_a;
   logic [3:0] src_b;
   logic [3:0] dst_e;
   logic [3:0] dst_m;

   always_comb begin
      src_a = REG_NONE;
      src_b = REG_NONE;
      dst_e = REG_NONE;
      dst_m = REG_NONE;
      case (bus.icode)
         I_RRMOVQ: begin
            src_a = bus.rA;
            if (bus.cnd) dst_e = bus.rB;
         end
         I_IRMOVQ: begin
            dst_e = bus.rB;
         end
         I_RMMOVQ: begin
            src_a = bus.rA;
            src_b = bus.rB;
         end
         I_MRMOVQ: begin
            src_b = bus.rB;
            dst_m = bus.rA;
         end
         I_OPQ: begin
            src_a = bus.rA;
            src_b = bus.rB;
            dst_e = bus.rB;
         end
         I_CALL: begin
            src_b = REG_RSP;
            dst_e = REG_RSP;
         end
         I_RET: begin
            src_a = REG_RSP;
            src_b = REG_RSP;
            dst_e = REG_RSP;
         end
         I_PUSHQ: begin
            src_a = bus.rA;
            src_b = REG_RSP;
            dst_e = REG_RSP;
         end
         I_POPQ: begin
            src_a = REG_RSP;
            src_b = REG_RSP;
            dst_e = REG_RSP;
            dst_m = bus.rA;
         end
         default: ;
      endcase
   end

   assign bus.srcA = src_a;
   assign bus.srcB = src_b;
   assign bus.dstE = dst_e;
   assign bus.dstM = dst_m;

   regfile u_regfile (
      .clk      (clk),
      .rst      (rst),
      .rd_a_id  (src_a),
      .rd_a_val (bus.valA),
      .rd_b_id  (src_b),
      .rd_b_val (bus.valB),
      .rd_d_id  (bus.dbg_sel),
      .rd_d_val (bus.dbg_val),
      .wr_en    (bus.wb_en),
      .wr_e_id  (dst_e),
      .wr_e_val (bus.valE),
      .wr_m_id  (dst_m),
      .wr_m_val (bus.valM)
   );

endmodule
